// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the sequential matrix-multiply engine.
package matmul_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef enum logic [2:0] {
    StIdle,
    StFetchA,
    StFetchB,
    StMac,
    StWrite,
    StDone
  } state_e;

  function automatic int unsigned elem_w(int unsigned size);
    return size;
  endfunction

  // Wide enough for N full-scale products, so the sum never wraps.
  function automatic int unsigned acc_w(int unsigned size, int unsigned n);
    return 2 * size + $clog2(n);
  endfunction

  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matmul_seq_engine_if.sv
// Matrix memory bus: combinational read port plus synchronous write port.
interface matmul_seq_engine_if #(
  parameter int unsigned SIZE = 8
);
  import matmul_pkg::*;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [SIZE-1:0]   rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [SIZE-1:0]   wr_data;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data
  );

endinterface

// File: rtl/matmul_mac.sv
// Unsigned multiply-accumulate with clear/enable and a high-bits overflow flag.
module matmul_mac #(
  parameter int unsigned SIZE = 8,
  parameter int unsigned ACCW = 17
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [SIZE-1:0] a_i,
  input  logic [SIZE-1:0] b_i,
  output logic [ACCW-1:0] acc_o,
  output logic            ovf_o
);

  logic [ACCW-1:0] acc_q;
  logic [ACCW-1:0] prod;

  always_comb begin
    prod  = ACCW'(a_i) * ACCW'(b_i);
    acc_o = acc_q;
    ovf_o = |acc_q[ACCW-1:SIZE];
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + prod;
    end
  end

endmodule

// File: rtl/matmul_seq_engine.sv
// Sequential C = A x B engine: one operand read per cycle, one MAC per term.
module matmul_seq_engine
  import matmul_pkg::*;
#(
  parameter int unsigned N      = 2,
  parameter int unsigned SIZE   = 8,
  parameter int unsigned A_BASE = 0,
  parameter int unsigned B_BASE = 4,
  parameter int unsigned C_BASE = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  matmul_seq_engine_if.master mem
);

  localparam int unsigned ACCW = acc_w(SIZE, N);
  localparam int unsigned EW   = elem_w(SIZE);
  localparam int unsigned IW   = idx_w(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     i_q, j_q, k_q;
  logic [EW-1:0]     a_q, b_q;
  logic              ovf_q;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic [EW-1:0]     wr_data_q;
  logic [ADDR_W-1:0] a_addr, b_addr, c_addr;
  logic [ACCW-1:0]   acc;
  logic              acc_hi;
  logic              mac_clr, mac_en;

  matmul_mac #(
    .SIZE (EW),
    .ACCW (ACCW)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (a_q),
    .b_i   (b_q),
    .acc_o (acc),
    .ovf_o (acc_hi)
  );

  always_comb begin
    a_addr  = ADDR_W'(A_BASE) + ADDR_W'(i_q) * ADDR_W'(N) + ADDR_W'(k_q);
    b_addr  = ADDR_W'(B_BASE) + ADDR_W'(k_q) * ADDR_W'(N) + ADDR_W'(j_q);
    c_addr  = ADDR_W'(C_BASE) + ADDR_W'(i_q) * ADDR_W'(N) + ADDR_W'(j_q);
    mac_clr = ((state_q == StIdle) && start) || (state_q == StWrite);
    mac_en  = (state_q == StMac);
  end

  always_comb begin
    state_d      = state_q;
    mem.rd_en    = 1'b0;
    mem.rd_addr  = rd_addr_q;
    mem.wr_en    = 1'b0;
    mem.wr_addr  = wr_addr_q;
    mem.wr_data  = wr_data_q;
    unique case (state_q)
      StIdle: if (start) state_d = StFetchA;
      StFetchA: begin
        mem.rd_en   = 1'b1;
        mem.rd_addr = a_addr;
        state_d     = StFetchB;
      end
      StFetchB: begin
        mem.rd_en   = 1'b1;
        mem.rd_addr = b_addr;
        state_d     = StMac;
      end
      StMac: state_d = (k_q == LAST) ? StWrite : StFetchA;
      StWrite: begin
        // Suppress the strobe on a reset cycle so an abort never lands a write.
        mem.wr_en   = ~rst;
        mem.wr_addr = c_addr;
        mem.wr_data = acc[EW-1:0];
        state_d     = ((i_q == LAST) && (j_q == LAST)) ? StDone : StFetchA;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      ovf_q     <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= mem.rd_addr;
      wr_addr_q <= mem.wr_addr;
      wr_data_q <= mem.wr_data;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            ovf_q <= 1'b0;
          end
        end
        StFetchA: a_q <= mem.rd_data;
        StFetchB: b_q <= mem.rd_data;
        StMac: if (k_q != LAST) k_q <= k_q + 1'b1;
        StWrite: begin
          if (acc_hi) ovf_q <= 1'b1;
          k_q <= '0;
          if (j_q == LAST) begin
            j_q <= '0;
            i_q <= (i_q == LAST) ? '0 : i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_matmul_seq_engine.sv
// Directed bench: N=2 and N=3 engines, each on its own behavioural matrix memory.
module tb_matmul_seq_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start2 = 1'b0;
  logic start3 = 1'b0;
  logic busy2, done2, ovf2, busy3, done3, ovf3;

  always #5 clk = ~clk;

  matmul_seq_engine_if #(.SIZE(8)) bus2 ();
  matmul_seq_engine_if #(.SIZE(8)) bus3 ();

  matmul_seq_engine #(
    .N(2), .SIZE(8), .A_BASE(0), .B_BASE(4), .C_BASE(8)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .overflow(ovf2),
    .mem(bus2)
  );

  matmul_seq_engine #(
    .N(3), .SIZE(8), .A_BASE(0), .B_BASE(9), .C_BASE(18)
  ) dut3 (
    .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3), .overflow(ovf3),
    .mem(bus3)
  );

  // Memories: combinational read gated by rd_en, synchronous write, bench preload port.
  logic [7:0]  mem2 [0:15];
  logic [7:0]  mem3 [0:31];
  logic        ld2_en = 1'b0, ld3_en = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic [31:0] wa2 [0:63];
  logic [7:0]  wd2 [0:63];
  logic [31:0] wa3 [0:63];
  logic [7:0]  wd3 [0:63];
  int nw2 = 0, nd2 = 0, bad2 = 0, nw3 = 0, nd3 = 0;

  assign bus2.rd_data = bus2.rd_en ? mem2[bus2.rd_addr[3:0]] : 8'h00;
  assign bus3.rd_data = bus3.rd_en ? mem3[bus3.rd_addr[4:0]] : 8'h00;

  always @(posedge clk) begin
    if (bus2.wr_en) begin
      mem2[bus2.wr_addr[3:0]] <= bus2.wr_data;
      if (nw2 < 64) begin
        wa2[nw2] <= bus2.wr_addr;
        wd2[nw2] <= bus2.wr_data;
      end
      nw2 <= nw2 + 1;
    end else if (ld2_en) begin
      mem2[ld_addr[3:0]] <= ld_data;
    end
    if (done2) nd2 <= nd2 + 1;
    if (bus2.rd_en && (bus2.rd_addr > 32'd7)) bad2 <= bad2 + 1;
  end

  always @(posedge clk) begin
    if (bus3.wr_en) begin
      mem3[bus3.wr_addr[4:0]] <= bus3.wr_data;
      if (nw3 < 64) begin
        wa3[nw3] <= bus3.wr_addr;
        wd3[nw3] <= bus3.wr_data;
      end
      nw3 <= nw3 + 1;
    end else if (ld3_en) begin
      mem3[ld_addr] <= ld_data;
    end
    if (done3) nd3 <= nd3 + 1;
  end

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input bit sel3, input int addr, input logic [7:0] d);
    @(negedge clk);
    ld_addr = 5'(addr);
    ld_data = d;
    ld2_en  = ~sel3;
    ld3_en  = sel3;
    @(negedge clk);
    ld2_en = 1'b0;
    ld3_en = 1'b0;
  endtask

  // av/bv pack the 2x2 operand matrices row-major, first element in the top byte.
  task automatic load2_all(input logic [31:0] av, input logic [31:0] bv, input logic [7:0] cf);
    for (int e = 0; e < 4; e++) begin
      load(1'b0, e, av[31-8*e -: 8]);
      load(1'b0, 4 + e, bv[31-8*e -: 8]);
      load(1'b0, 8 + e, cf);
    end
  endtask

  task automatic wait_done2(inout int cyc);
    while (done2 !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Pulse start; returns the cycle (start edge = cycle 0) in which done is seen.
  task automatic run2(output int cyc);
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 1;
    wait_done2(cyc);
  endtask

  task automatic check_writes2(input string pfx, input int w0, input logic [31:0] ev);
    check({pfx, "_nwrites"}, nw2 - w0, 4);
    for (int e = 0; e < 4; e++) begin
      check($sformatf("%s_wr%0d_addr", pfx, e), wa2[w0 + e], 8 + e);
      check($sformatf("%s_wr%0d_data", pfx, e), wd2[w0 + e], ev[31-8*e -: 8]);
    end
  endtask

  int cyc, w0, d0, b0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy2, 0);
    check("rst_done", done2, 0);
    check("rst_ovf", ovf2, 0);
    check("rst_rd_en", bus2.rd_en, 0);
    check("rst_wr_en", bus2.wr_en, 0);
    check("rst_rd_addr", bus2.rd_addr, 0);
    check("rst_wr_addr", bus2.wr_addr, 0);
    check("rst_wr_data", bus2.wr_data, 0);
    rst = 1'b0;

    // A=[1,2;3,4] B=[5,6;7,8] -> C=[19,22;43,50]
    load2_all(32'h01020304, 32'h05060708, 8'h00);
    w0 = nw2; d0 = nd2;
    run2(cyc);
    check("t1_done_cycle", cyc, 29);
    check("t1_busy_in_done", busy2, 1);
    @(negedge clk);
    check("t1_busy_after", busy2, 0);
    check("t1_done_after", done2, 0);
    check("t1_ndone", nd2 - d0, 1);
    check("t1_ovf", ovf2, 0);
    check_writes2("t1", w0, 32'h13162B32);

    // Identity x [9,8;7,6]; no read outside A/B
    load2_all(32'h01000001, 32'h09080706, 8'h00);
    w0 = nw2; b0 = bad2;
    run2(cyc);
    @(negedge clk);
    check("t2_done_cycle", cyc, 29);
    check_writes2("t2", w0, 32'h09080706);
    check("t2_mem8", mem2[8], 9);
    check("t2_mem11", mem2[11], 6);
    check("t2_bad_reads", bad2 - b0, 0);

    // All 255: acc = 2*65025 = 130050 = 0x1FC02, truncated to 0x02, overflow sticks
    load2_all(32'hFFFFFFFF, 32'hFFFFFFFF, 8'h00);
    w0 = nw2;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 1;
    while (cyc < 7) begin
      @(negedge clk);
      cyc++;
    end
    check("t3_wr_en_c7", bus2.wr_en, 1);
    check("t3_wr_addr_c7", bus2.wr_addr, 8);
    check("t3_acc_c7", dut2.u_mac.acc_o, 130050);
    check("t3_wr_data_c7", bus2.wr_data, 2);
    check("t3_ovf_c7", ovf2, 0);
    @(negedge clk);
    cyc++;
    check("t3_ovf_c8", ovf2, 1);
    wait_done2(cyc);
    check("t3_done_cycle", cyc, 29);
    @(negedge clk);
    check("t3_ovf_after_done", ovf2, 1);
    check_writes2("t3", w0, 32'h02020202);

    // start held through most of the run: ignored while busy; new start clears overflow
    load2_all(32'h01020304, 32'h05060708, 8'h00);
    w0 = nw2; d0 = nd2;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    cyc = 1;
    check("t4_ovf_cleared", ovf2, 0);
    while (cyc < 27) begin
      @(negedge clk);
      cyc++;
    end
    start2 = 1'b0;
    wait_done2(cyc);
    check("t4_done_cycle", cyc, 29);
    repeat (3) @(negedge clk);
    check("t4_busy_idle", busy2, 0);
    check("t4_ndone", nd2 - d0, 1);
    check_writes2("t4", w0, 32'h13162B32);
    w0 = nw2;
    run2(cyc);
    @(negedge clk);
    check("t4b_done_cycle", cyc, 29);
    check("t4b_ovf", ovf2, 0);
    check_writes2("t4b", w0, 32'h13162B32);

    // Reset in cycle 10: only C[0][0] lands, then a clean rerun
    load2_all(32'h01020304, 32'h05060708, 8'hEE);
    w0 = nw2;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    rst = 1'b1;
    @(negedge clk);
    check("t5_busy_after_rst", busy2, 0);
    check("t5_wr_en_after_rst", bus2.wr_en, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("t5_nwrites", nw2 - w0, 1);
    check("t5_mem8", mem2[8], 19);
    check("t5_mem9", mem2[9], 8'hEE);
    check("t5_mem10", mem2[10], 8'hEE);
    check("t5_mem11", mem2[11], 8'hEE);
    w0 = nw2;
    run2(cyc);
    @(negedge clk);
    check("t5b_done_cycle", cyc, 29);
    check_writes2("t5b", w0, 32'h13162B32);

    // N=3, A=B=all ones -> nine 3s at 18..26, done in cycle 9*10+1
    for (int a = 0; a < 27; a++) load(1'b1, a, (a < 18) ? 8'd1 : 8'd0);
    w0 = nw3; d0 = nd3;
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    cyc = 1;
    while (done3 !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_done_cycle", cyc, 91);
    @(negedge clk);
    check("t6_nwrites", nw3 - w0, 9);
    check("t6_ndone", nd3 - d0, 1);
    check("t6_ovf", ovf3, 0);
    for (int e = 0; e < 9; e++) begin
      check($sformatf("t6_wr%0d_addr", e), wa3[w0 + e], 18 + e);
      check($sformatf("t6_wr%0d_data", e), wd3[w0 + e], 3);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/matmul_seq_engine.md
Name: matmul_seq_engine

Overview:
- Sequential controller and datapath that computes C = A x B for square unsigned N x N matrices held row-major in the shared matrix memory.
- Reads operands one element per cycle over a single combinational-read port and accumulates each C element with a single multiply-accumulate.
- Writes each finished element through the memory's synchronous write port, then signals completion.
- Sits directly upstream of the matrix memory: it drives that memory's address, read and write controls.

Parameters:
- N, 2, matrix dimension (rows = columns); legal range 2..8
- SIZE, 8, element width in bits; matches memory word width
- A_BASE, 0, word address of A[0][0]
- B_BASE, 4, word address of B[0][0]
- C_BASE, 8, word address of C[0][0]; memory depth must be at least C_BASE + N*N (default needs 12 words)
- ACCW, 2*SIZE+$clog2(N), accumulator width (derived; do not override)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on completion
- overflow  out  1  sticky; set if any C element exceeded SIZE bits in the current run
- rd_en  out  1  read strobe to memory
- rd_addr  out  32  memory read address
- rd_data  in  SIZE  memory read data, combinational from rd_addr
- wr_en  out  1  write strobe to memory
- wr_addr  out  32  memory write address
- wr_data  out  SIZE  memory write data

Behaviour:
- One clock domain. Reset is synchronous and active-high; clock port is clk, reset port is rst.
- Reset values:
  - state = IDLE
  - busy = done = overflow = rd_en = wr_en = 0
  - rd_addr = wr_addr = 0, wr_data = 0
  - i, j, k indices = 0; acc = 0; a_reg = b_reg = 0
- FSM states: IDLE, FETCH_A, FETCH_B, MAC, WRITE, DONE.
- IDLE:
  - start=1 at an edge moves to FETCH_A.
  - On that same edge: i = j = k = 0, acc = 0, overflow cleared.
- FETCH_A:
  - rd_en = 1, rd_addr = A_BASE + i*N + k.
  - a_reg <= rd_data; go to FETCH_B.
- FETCH_B:
  - rd_en = 1, rd_addr = B_BASE + k*N + j.
  - b_reg <= rd_data; go to MAC.
- MAC:
  - acc <= acc + a_reg*b_reg, unsigned, full ACCW width; acc never wraps.
  - If k < N-1: k++, go to FETCH_A. Otherwise go to WRITE.
- WRITE:
  - wr_en = 1, wr_addr = C_BASE + i*N + j, wr_data = acc[SIZE-1:0] (truncation).
  - If acc[ACCW-1:SIZE] != 0, overflow <= 1.
  - On the edge: acc <= 0, k <= 0, then advance j; when j wraps, advance i.
  - If i = j = N-1, go to DONE. Otherwise go to FETCH_A.
- DONE:
  - done = 1 for exactly one cycle, then go to IDLE.
  - overflow holds its value until the next accepted start.
- Outputs outside their own state:
  - rd_en and wr_en are 0.
  - rd_addr and wr_addr hold their last values. This is legal because the memory read responds only while rd_en is high.
- Latency:
  - Each C element takes 3N+1 cycles.
  - A full run takes N*N*(3N+1) cycles from the start edge to the last WRITE, plus 1 DONE cycle.
  - N=2: 28 busy cycles, then done high in cycle 29.
- C is written in row-major order, one write per element. The engine never writes A or B.
- start while busy: ignored; no restart, no error.
- start held high through DONE: a new run begins on the first IDLE edge.
- rst mid-run: back to IDLE next edge, no further writes. Elements already written stay in memory.
- In-place aliasing (C overlapping A or B) is not supported; results are undefined.

Decomposition:
- Package matmul_pkg:
  - state enum (IDLE..DONE)
  - ADDR_W = 32
  - element and accumulator width helper functions
- One sub-module, matmul_mac:
  - registered ACCW accumulator with clear and enable
  - unsigned SIZE x SIZE multiply
  - overflow compare of the high bits
- The FSM, index counters and address generation stay in matmul_seq_engine.

Test Plan:
- Memory A=[1,2;3,4], B=[5,6;7,8], pulse start -> writes 19@8, 22@9, 43@10, 50@11 in that order; done pulses in cycle 29; overflow=0.
- A=identity, B=[9,8;7,6] -> C = 9, 8, 7, 6 at addresses 8..11; the only rd addresses seen are 0..7.
- A all 255, B all 255 -> each acc = 130050; wr_data = 0x02 at each of 8..11; overflow=1 after the first WRITE, still 1 after done.
- Assert start repeatedly during busy -> exactly 4 writes and one done pulse. A second start after done clears overflow and repeats the results.
- Assert rst at cycle 10 of a run -> busy=0 and wr_en=0 next cycle; only C[0][0] (written at cycle 7) changed; the next start completes normally.
- N=3 build, A=B=all 1 -> nine writes of 3 at addresses C_BASE..C_BASE+8; done at cycle 9*10+1 = 91.
